// File: rtl/nf_10g_stats_pkg.sv
// ---------------------------------------------------------------------------
// nf_10g_stats_pkg
// Shared definitions for the 10G RX statistics stage:
//   - register-port address constants
//   - position of the packet-length field inside tuser
//   - popcount helper for tkeep (up to KEEP_MAX_W lanes)
// ---------------------------------------------------------------------------
package nf_10g_stats_pkg;

    // Register map for stat_rd_addr
    localparam logic [2:0] STAT_PKT       = 3'd0;
    localparam logic [2:0] STAT_BYTE      = 3'd1;
    localparam logic [2:0] STAT_LEN_ERR   = 3'd2;
    localparam logic [2:0] STAT_LINK_DOWN = 3'd3;
    localparam logic [2:0] STAT_LINK      = 3'd4;

    // tuser[15:0] carries the declared packet length in bytes
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_MSB = 15;
    localparam int LEN_W         = TUSER_LEN_MSB - TUSER_LEN_LSB + 1;

    // Widest tkeep the popcount helper handles; narrower keeps are zero-extended
    localparam int KEEP_MAX_W = 64;
    localparam int POP_W      = 8;

    function automatic logic [POP_W-1:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            cnt = cnt + {{(POP_W-1){1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/nf_axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// nf_axis_skid_buffer
// Two-entry AXI-Stream skid buffer carrying an opaque W-bit payload.
// The output always presents the oldest entry; s_ready is a registered
// "not full" so the upstream ready path never depends on m_ready.
//
// Ports:
//   axis_aclk     clock
//   axis_aresetn  synchronous active-low reset
//   s_data/s_valid/s_ready  input side
//   m_data/m_valid/m_ready  output side
// ---------------------------------------------------------------------------
module nf_axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         axis_aclk,
    input  logic         axis_aresetn,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    localparam int DEPTH = 2;

    logic [W-1:0] entry_reg  [DEPTH];
    logic [W-1:0] entry_next [DEPTH];
    logic [1:0]   count_reg;
    logic [1:0]   count_next;
    logic         ready_reg;
    logic         push;
    logic         pop;

    assign push    = s_valid && ready_reg;
    assign pop     = (count_reg != 2'd0) && m_ready;
    assign s_ready = ready_reg;
    assign m_valid = (count_reg != 2'd0);
    assign m_data  = entry_reg[0];

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        count_next    = count_reg;
        entry_next[0] = entry_reg[0];
        entry_next[1] = entry_reg[1];
        case ({push, pop})
            2'b10: begin
                count_next = count_reg + 2'd1;
                if (count_reg == 2'd0) begin
                    entry_next[0] = s_data;
                end else begin
                    entry_next[1] = s_data;
                end
            end
            2'b01: begin
                count_next    = count_reg - 2'd1;
                entry_next[0] = entry_reg[1];
            end
            2'b11: begin
                // Occupancy unchanged; push can only happen with count<=1
                if (count_reg == 2'd1) begin
                    entry_next[0] = s_data;
                end else begin
                    entry_next[0] = entry_reg[1];
                    entry_next[1] = s_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            count_reg <= 2'd0;
            ready_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != 2'd2);
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

endmodule

// File: rtl/nf_10g_rx_stats.sv
// ---------------------------------------------------------------------------
// nf_10g_rx_stats
// Per-port RX statistics stage between the 10G interface and the input
// arbiter. Forwards the stream unchanged through a 2-entry skid buffer and
// keeps saturating packet / byte / length-error / link-drop counters that
// are read through a one-cycle request/acknowledge port.
//
// Ports:
//   axis_aclk, axis_aresetn        clock, synchronous active-low reset
//   s_axis_*                       RX stream in (from 10G interface)
//   m_axis_*                       RX stream out (to arbiter)
//   link_up                        PCS/PMA link status, already synchronous
//   stat_rd_req/addr               read strobe and counter select
//   stat_rd_data/ack               read data, valid one cycle after request
//   stat_clear                     strobe clearing all counters
// ---------------------------------------------------------------------------
module nf_10g_rx_stats
    import nf_10g_stats_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic                            link_up,
    input  logic                            stat_rd_req,
    input  logic [2:0]                      stat_rd_addr,
    output logic [C_CNT_WIDTH-1:0]          stat_rd_data,
    output logic                            stat_rd_ack,
    input  logic                            stat_clear
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int BUF_W  = C_AXIS_DATA_WIDTH + KEEP_W + C_AXIS_TUSER_WIDTH + 1;

    // ------------------------------------------------------------------
    // Stream path
    // ------------------------------------------------------------------
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;

    assign buf_in = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = buf_out;

    nf_axis_skid_buffer #(
        .W (BUF_W)
    ) u_skid (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .s_data       (buf_in),
        .s_valid      (s_axis_tvalid),
        .s_ready      (s_axis_tready),
        .m_data       (buf_out),
        .m_valid      (m_axis_tvalid),
        .m_ready      (m_axis_tready)
    );

    // ------------------------------------------------------------------
    // Per-beat length tracking (input handshakes only)
    // ------------------------------------------------------------------
    logic                   in_hs;
    logic                   first_beat;
    logic [KEEP_MAX_W-1:0]  keep_ext;
    logic [POP_W-1:0]       beat_bytes;
    logic [LEN_W-1:0]       frame_total;
    logic [LEN_W-1:0]       exp_len;
    logic                   len_bad;

    logic                   in_pkt_reg;
    logic [LEN_W-1:0]       acc_reg;
    logic [LEN_W-1:0]       exp_len_reg;

    assign in_hs      = s_axis_tvalid && s_axis_tready;
    assign first_beat = !in_pkt_reg;
    assign keep_ext   = KEEP_MAX_W'(s_axis_tkeep);
    assign beat_bytes = popcount_keep(keep_ext);

    // A first beat restarts the accumulator and supplies the declared length
    // directly, which also covers single-beat packets.
    assign frame_total = (first_beat ? '0 : acc_reg) + LEN_W'(beat_bytes);
    assign exp_len     = first_beat ? s_axis_tuser[TUSER_LEN_MSB:TUSER_LEN_LSB] : exp_len_reg;
    assign len_bad     = (frame_total != exp_len);

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            in_pkt_reg  <= 1'b0;
            acc_reg     <= '0;
            exp_len_reg <= '0;
        end else if (in_hs) begin
            in_pkt_reg <= !s_axis_tlast;
            acc_reg    <= frame_total;
            if (first_beat) begin
                exp_len_reg <= s_axis_tuser[TUSER_LEN_MSB:TUSER_LEN_LSB];
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters; clear has priority over any increment
    // ------------------------------------------------------------------
    function automatic logic [C_CNT_WIDTH-1:0] sat_add(
        input logic [C_CNT_WIDTH-1:0] a,
        input logic [C_CNT_WIDTH-1:0] b
    );
        logic [C_CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[C_CNT_WIDTH] ? '1 : sum[C_CNT_WIDTH-1:0];
    endfunction

    logic                   link_prev_reg;
    logic                   link_fall;
    logic [C_CNT_WIDTH-1:0] pkt_inc;
    logic [C_CNT_WIDTH-1:0] byte_inc;
    logic [C_CNT_WIDTH-1:0] len_err_inc;
    logic [C_CNT_WIDTH-1:0] link_down_inc;

    logic [C_CNT_WIDTH-1:0] pkt_cnt_reg;
    logic [C_CNT_WIDTH-1:0] byte_cnt_reg;
    logic [C_CNT_WIDTH-1:0] len_err_cnt_reg;
    logic [C_CNT_WIDTH-1:0] link_down_cnt_reg;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_next;
    logic [C_CNT_WIDTH-1:0] byte_cnt_next;
    logic [C_CNT_WIDTH-1:0] len_err_cnt_next;
    logic [C_CNT_WIDTH-1:0] link_down_cnt_next;

    assign link_fall     = link_prev_reg && !link_up;
    assign pkt_inc       = C_CNT_WIDTH'(in_hs && s_axis_tlast);
    assign byte_inc      = in_hs ? C_CNT_WIDTH'(beat_bytes) : '0;
    assign len_err_inc   = C_CNT_WIDTH'(in_hs && s_axis_tlast && len_bad);
    assign link_down_inc = C_CNT_WIDTH'(link_fall);

    always_comb begin
        pkt_cnt_next       = sat_add(pkt_cnt_reg, pkt_inc);
        byte_cnt_next      = sat_add(byte_cnt_reg, byte_inc);
        len_err_cnt_next   = sat_add(len_err_cnt_reg, len_err_inc);
        link_down_cnt_next = sat_add(link_down_cnt_reg, link_down_inc);
        if (stat_clear) begin
            pkt_cnt_next       = '0;
            byte_cnt_next      = '0;
            len_err_cnt_next   = '0;
            link_down_cnt_next = '0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            pkt_cnt_reg       <= '0;
            byte_cnt_reg      <= '0;
            len_err_cnt_reg   <= '0;
            link_down_cnt_reg <= '0;
            link_prev_reg     <= 1'b0;
        end else begin
            pkt_cnt_reg       <= pkt_cnt_next;
            byte_cnt_reg      <= byte_cnt_next;
            len_err_cnt_reg   <= len_err_cnt_next;
            link_down_cnt_reg <= link_down_cnt_next;
            link_prev_reg     <= link_up;
        end
    end

    // ------------------------------------------------------------------
    // Register read port: samples the pre-update counter values, so a read
    // coinciding with a clear returns the old contents.
    // ------------------------------------------------------------------
    logic [C_CNT_WIDTH-1:0] rd_mux;
    logic [C_CNT_WIDTH-1:0] rd_data_reg;
    logic                   rd_ack_reg;

    always_comb begin
        rd_mux = '0;
        case (stat_rd_addr)
            STAT_PKT:       rd_mux = pkt_cnt_reg;
            STAT_BYTE:      rd_mux = byte_cnt_reg;
            STAT_LEN_ERR:   rd_mux = len_err_cnt_reg;
            STAT_LINK_DOWN: rd_mux = link_down_cnt_reg;
            STAT_LINK:      rd_mux = C_CNT_WIDTH'(link_up);
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            rd_ack_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            rd_ack_reg  <= stat_rd_req;
            rd_data_reg <= stat_rd_req ? rd_mux : '0;
        end
    end

    assign stat_rd_ack  = rd_ack_reg;
    assign stat_rd_data = rd_data_reg;

endmodule

// File: doc/nf_10g_rx_stats.md
# nf_10g_rx_stats

Per-port receive statistics stage on the core clock domain. It sits directly downstream of the 10G interface block's 256-bit RX AXI-Stream output and upstream of the input arbiter. It forwards the stream through a 2-entry skid buffer without modification. Alongside the stream it keeps saturating packet, byte, length-error and link-drop counters, which are readable through a simple request/acknowledge register port.

## Interface
- C_AXIS_DATA_WIDTH, 256, stream data width (tkeep width is C_AXIS_DATA_WIDTH/8).
- C_AXIS_TUSER_WIDTH, 128, tuser width; [15:0] carries the packet length in bytes.
- C_CNT_WIDTH, 32, width of every counter and of stat_rd_data.

Ports:
- axis_aclk  in  1  sole clock.
- axis_aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata / tkeep / tuser / tvalid / tlast  in  per parameters  RX stream from the 10G interface.
- s_axis_tready  out  1  backpressure to the 10G interface.
- m_axis_tdata / tkeep / tuser / tvalid / tlast  out  per parameters  forwarded stream to the arbiter.
- m_axis_tready  in  1  backpressure from the arbiter.
- link_up  in  1  pcspma_status[0], already synchronous to axis_aclk.
- stat_rd_req  in  1  single-cycle read strobe.
- stat_rd_addr  in  3  counter select.
- stat_rd_data  out  C_CNT_WIDTH  read data, valid with stat_rd_ack.
- stat_rd_ack  out  1  one-cycle acknowledge.
- stat_clear  in  1  single-cycle strobe that clears all counters.

## Operation
- Skid buffer: 2 entries.
  - s_axis_tready = buffer not full (registered).
  - m_axis_* always presents the oldest entry.
  - Data, keep, user and last are forwarded bit-exact; beat order is preserved.
- Counting uses input handshakes only (s_axis_tvalid && s_axis_tready).
- On each first beat of a packet, capture tuser[15:0] as the expected length and reset the length accumulator.
- Each beat adds popcount(tkeep), 0..32, to the frame accumulator (16 bits) and to the byte counter.
- On the tlast beat:
  - pkt_cnt += 1.
  - If accumulator + this beat's count != expected length, len_err_cnt += 1.
- A single-beat packet is both first and last in the same cycle; the comparison uses that beat's tuser.
- link_down_cnt += 1 on each 1→0 transition of link_up. The previous link_up value is reset to 0, so no count occurs on the first cycle.
- All counters saturate at 2^C_CNT_WIDTH−1. There is no wrap.
- stat_clear zeroes all counters. If an increment and a clear land in the same cycle, the clear wins and the result is 0.
- Register map for stat_rd_addr:
  - 0: pkt_cnt.
  - 1: byte_cnt.
  - 2: len_err_cnt.
  - 3: link_down_cnt.
  - 4: {0, link_up}.
  - 5–7: 0.
- A read and a clear in the same cycle return the pre-clear value.
- Reset clears counters, skid buffer, the in-packet flag and the previous link_up value. A packet that is mid-flight at reset is discarded from statistics.

## Timing
- Stream latency: 1 cycle from input handshake to m_axis_tvalid when the buffer is empty.
- Throughput: 1 beat/cycle sustained while m_axis_tready is high.
- Backpressure: m_axis_tready low for 2+ cycles drops s_axis_tready after 2 accepted beats. It reasserts the cycle after the first output handshake.
- Simultaneous input and output handshake on a 1-entry buffer keeps it at 1 entry; s_axis_tready stays high.
- Counter visibility: each counter reflects a handshake on the cycle after it.
- Register read: stat_rd_ack and stat_rd_data are valid exactly 1 cycle after stat_rd_req, for one cycle. Back-to-back requests are each acknowledged.
- Reset values of outputs:
  - m_axis_tvalid = 0.
  - s_axis_tready = 0 during reset, 1 on the first cycle after reset.
  - stat_rd_ack = 0 and stat_rd_data = 0.
  - m_axis data, keep, user and last = 0.

## Structure
- Shared package nf_10g_stats_pkg holds:
  - the register address constants (STAT_PKT=0 … STAT_LINK=4);
  - the tuser length field position [15:0];
  - a popcount function for the tkeep width.
- One sub-module: nf_axis_skid_buffer, parameterized on the concatenated {tdata, tkeep, tuser, tlast} width.
- Counters, length check and register port live in the top level.

## Test plan
- Three 64-byte packets (2 full beats each, tuser[15:0]=64), m_axis_tready=1 → output beats identical to input, 1-cycle latency; reads return pkt=3, bytes=192, len_err=0.
- One 70-byte packet (beats with tkeep all-ones, then 0x3F) declaring tuser length 72 → len_err=1, bytes=70, pkt=1.
- m_axis_tready held low for 5 cycles during a 4-beat burst → s_axis_tready drops after 2 beats; no beat lost or duplicated; counts still total 4 beats.
- link_up sequence 1,0,1,0 → link_down=2; read address 4 returns the current link_up.
- Counters preloaded by force to 0xFFFFFFFF, then one packet → stays 0xFFFFFFFF; stat_clear asserted with a tlast handshake → pkt=0; a read in the same cycle as the clear returns the old value.
- axis_aresetn asserted mid-packet, then a fresh 1-beat 32-byte packet → pkt=1, bytes=32, len_err=0; no stale beat is emitted.
